// File: rtl/palette_lut_dbuf.sv
// Double-buffered colour palette: host edits a shadow bank and the banks swap
// only at a frame boundary, after which the new shadow is refreshed from the active bank.
module palette_lut_dbuf #(
    parameter int IDX_W    = 4,
    parameter int CODE_W   = 10,
    parameter int RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [CODE_W-1:0]            i_wr_code,
    input  logic                         i_swap_req,
    input  logic                         i_frame_start,
    output logic                         o_swap_pending,
    output logic                         o_init_done,
    output logic                         o_active_bank,
    input  logic [RD_PORTS*IDX_W-1:0]    i_rd_idx,
    output logic [RD_PORTS*CODE_W-1:0]   o_rd_code
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ARMED = 2'd2,
        S_COPY  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W:0]      r_cnt;
    logic                r_active_bank;
    logic                r_copy_swap;
    logic [CODE_W-1:0]   r_mem [0:2*DEPTH-1];

    logic                w_cnt_last;
    logic [IDX_W-1:0]    w_cnt_idx;
    logic                w_wr_fire;
    logic                w_swap_now;

    function automatic logic [CODE_W-1:0] f_default_code(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(0))
            return CODE_W'(10'b0001100100);
        else if (idx == IDX_W'(1))
            return CODE_W'(10'b0100010111);
        else
            return '0;
    endfunction

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_cnt_idx  = r_cnt[IDX_W-1:0];
    assign w_wr_fire  = i_wr_valid & o_wr_ready;
    assign w_swap_now = (r_state == S_ARMED) & i_frame_start;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= S_INIT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (w_cnt_last) w_state_nxt = S_IDLE;
            S_IDLE:  if (i_swap_req) w_state_nxt = S_ARMED;
            S_ARMED: if (i_frame_start) w_state_nxt = S_COPY;
            S_COPY: begin
                // A swap requested at any point of the copy, including its last cycle, re-arms.
                if (w_cnt_last)
                    w_state_nxt = (r_copy_swap | i_swap_req) ? S_ARMED : S_IDLE;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        o_wr_ready     = 1'b0;
        o_init_done    = 1'b1;
        o_swap_pending = 1'b0;
        case (r_state)
            S_INIT:  o_init_done    = 1'b0;
            S_IDLE:  o_wr_ready     = 1'b1;
            S_ARMED: o_swap_pending = 1'b1;
            S_COPY:  o_swap_pending = r_copy_swap;
            default: o_init_done    = 1'b0;
        endcase
    end

    assign o_active_bank = r_active_bank;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_active_bank <= 1'b0;
            r_copy_swap   <= 1'b0;
        end else begin
            if (r_state == S_INIT || r_state == S_COPY)
                r_cnt <= r_cnt + CNT_ONE;
            else if (w_swap_now)
                r_cnt <= '0;

            if (w_swap_now)
                r_active_bank <= ~r_active_bank;

            if (r_state != S_COPY || w_cnt_last)
                r_copy_swap <= 1'b0;
            else if (i_swap_req)
                r_copy_swap <= 1'b1;
        end
    end

    // Storage: bank select is the address MSB; the shadow bank is always ~active.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            case (r_state)
                S_INIT: begin
                    r_mem[{1'b0, w_cnt_idx}] <= f_default_code(w_cnt_idx);
                    r_mem[{1'b1, w_cnt_idx}] <= f_default_code(w_cnt_idx);
                end
                S_IDLE: begin
                    if (w_wr_fire)
                        r_mem[{~r_active_bank, i_wr_idx}] <= i_wr_code;
                end
                S_COPY: begin
                    r_mem[{~r_active_bank, w_cnt_idx}] <= r_mem[{r_active_bank, w_cnt_idx}];
                end
                default: ;
            endcase
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [IDX_W-1:0]  w_rd_idx;
        logic [CODE_W-1:0] r_rd_code_p1;

        assign w_rd_idx = i_rd_idx[p*IDX_W +: IDX_W];

        // Read stage p0 -> p1: active bank sampled together with the index.
        always_ff @(posedge clk) begin
            if (!reset_n || r_state == S_INIT)
                r_rd_code_p1 <= '0;
            else
                r_rd_code_p1 <= r_mem[{r_active_bank, w_rd_idx}];
        end

        assign o_rd_code[p*CODE_W +: CODE_W] = r_rd_code_p1;
    end

endmodule
